conv_loop_sched: RTL and testbench
==================================

CONV_LOOP_SCHED -- requirements
Module: conv_loop_sched

Interface
REQ-001 Parameter MAX_K, default 7, largest supported kernel dimension.
REQ-002 Parameter MAX_O, default 64, largest supported output feature-map dimension.
REQ-003 Parameter KW, default $clog2(MAX_K+1), width of the kernel configuration and kernel index ports.
REQ-004 Parameter OW, default $clog2(MAX_O+1), width of the output configuration and output index ports.
REQ-005 Clock and reset SHALL be one clock and one synchronous, active-low reset; ports are named as in the rest of the codebase.
REQ-006 Port clk, input, 1, rising-edge clock.
REQ-007 Port reset, input, 1, synchronous active-low reset.
REQ-008 Port start, input, 1, launch pulse (sampled only in IDLE).
REQ-009 Port abort, input, 1, terminate the current run.
REQ-010 Port cfg_kdim, input, KW, kernel dimension K (latched at start).
REQ-011 Port cfg_odim, input, OW, output dimension O (latched at start).
REQ-012 Port idx_kx / idx_ky, output, KW each, current kernel column and row.
REQ-013 Port idx_ox / idx_oy, output, OW each, current output column and row.
REQ-014 Port idx_vld, output, 1, the index tuple is valid.
REQ-015 Port idx_rdy, input, 1, the datapath accepts the tuple.
REQ-016 Port acc_clr, output, 1, the current tuple is the first kernel element of a window (kx=ky=0).
REQ-017 Port acc_last, output, 1, the current tuple is the last kernel element of a window (kx=ky=K-1).
REQ-018 Port busy, output, 1, the state is not IDLE.
REQ-019 Port done, output, 1, one-cycle completion pulse.

Function
REQ-020 FSM states: IDLE, RUN, DONE, encoded as a 2-bit state.
REQ-021 IDLE->RUN on start=1 when K!=0 and O!=0; cfg is latched on the same edge and all indices are zeroed.
REQ-022 IDLE->DONE on start=1 when K==0 or O==0; no beats are issued.
REQ-023 In RUN, idx_vld=1 continuously; the first tuple is presented the cycle after start (1-cycle latency).
REQ-024 A beat occurs on the cycle where idx_vld&&idx_rdy; indices SHALL advance only on a beat and hold otherwise.
REQ-025 Iteration order, fastest to slowest: kx, ky, ox, oy; each level wraps K-1->0 (or O-1->0) and carries to the next level.
REQ-026 Total beats per run SHALL equal O*O*K*K.
REQ-027 A beat on the final tuple (all indices at max) moves RUN->DONE; idx_vld=0 from the next cycle.
REQ-028 DONE lasts exactly one cycle with done=1, then moves to IDLE.
REQ-029 abort=1 in RUN moves to IDLE on the next edge with no done pulse; abort has priority over a simultaneous beat.
REQ-030 start is ignored in RUN and DONE; cfg changes outside the start cycle have no effect.
REQ-031 acc_clr and acc_last are combinational from indices and state, and are qualified by idx_vld; when K=1 both are 1 on every beat.
REQ-032 Index outputs SHALL be 0 whenever not in RUN.

Reset
REQ-033 reset=0 at a clock edge forces IDLE, zeroes all indices and latched cfg, and makes idx_vld=0, busy=0, done=0, acc_clr=0, acc_last=0.
REQ-034 Reset mid-run SHALL abandon the run with no done pulse; the first start after reset release behaves as in REQ-021.

Structure
REQ-035 A shared package holds the state enum (IDLE, RUN, DONE) and the default MAX_K and MAX_O constants.
REQ-036 Sub-module loop_level: one wrapping counter per loop level with inputs clr, inc, and limit, and outputs value and at_max; it is instantiated four times and chained via at_max&&inc.
REQ-037 Next-state logic and outputs live in conv_loop_sched; there is no other hierarchy.

Verification
REQ-038 K=3, O=2, idx_rdy=1 constantly, start pulse: 36 beats on consecutive cycles, 4 acc_clr, 4 acc_last, done 1 cycle after the last beat, busy low the following cycle.
REQ-039 K=2, O=2, idx_rdy toggled 1/0 each cycle: indices hold during rdy=0, exactly 16 beats occur, and the order matches REQ-025.
REQ-040 K=0, O=5, start pulse: idx_vld never rises, done=1 exactly on the cycle after start.
REQ-041 K=3, O=4, abort asserted on beat 10 with rdy=1: no done pulse, IDLE next cycle, and a new start restarts at all-zero indices.
REQ-042 K=3, O=4, reset=0 for one cycle mid-run: all outputs zero the next cycle; start asserted during RUN with no reset is ignored (beat count unchanged).
REQ-043 K=1, O=3: 9 beats, each with acc_clr=acc_last=1; ox and oy wrap correctly at 2->0.

Source files
------------

// File: rtl/conv_loop_sched_pkg.sv
// Shared definitions for the convolution loop scheduler: FSM state encoding
// and the default loop bounds.
package conv_loop_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_MAX_K = 7;
  localparam int DEF_MAX_O = 64;

endpackage

// File: rtl/conv_loop_sched_loop_level.sv
// One level of the nested convolution loop: a counter that wraps at limit-1
// and flags its last value so the next level can carry.
module loop_level #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] value,
  output logic         at_max
);

  logic [W-1:0] value_q, value_d;

  assign at_max = (value_q == limit - W'(1));
  assign value  = value_q;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = at_max ? '0 : value_q + W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/conv_loop_sched.sv
// Convolution loop scheduler: walks kx, ky, ox, oy (fastest first) over a
// K x K kernel and O x O output map, one index tuple per accepted beat.
module conv_loop_sched
  import conv_loop_sched_pkg::*;
#(
  parameter int MAX_K = DEF_MAX_K,
  parameter int MAX_O = DEF_MAX_O,
  parameter int KW    = $clog2(MAX_K + 1),
  parameter int OW    = $clog2(MAX_O + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [KW-1:0] cfg_kdim,
  input  logic [OW-1:0] cfg_odim,
  output logic [KW-1:0] idx_kx,
  output logic [KW-1:0] idx_ky,
  output logic [OW-1:0] idx_ox,
  output logic [OW-1:0] idx_oy,
  output logic          idx_vld,
  input  logic          idx_rdy,
  output logic          acc_clr,
  output logic          acc_last,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [KW-1:0] kdim_q, kdim_d;
  logic [OW-1:0] odim_q, odim_d;

  logic [KW-1:0] kx, ky;
  logic [OW-1:0] ox, oy;
  logic          kx_max, ky_max, ox_max, oy_max;
  logic          run, beat, step, cnt_clr, final_tuple;

  assign run         = (state_q == ST_RUN);
  assign beat        = run && idx_rdy;
  // Abort wins over a simultaneous beat: the counters are cleared, not stepped.
  assign step        = beat && !abort;
  assign cnt_clr     = !run || abort;
  assign final_tuple = kx_max && ky_max && ox_max && oy_max;

  loop_level #(.W(KW)) u_kx (
    .clk(clk), .reset(reset), .clr(cnt_clr), .inc(step),
    .limit(kdim_q), .value(kx), .at_max(kx_max)
  );
  loop_level #(.W(KW)) u_ky (
    .clk(clk), .reset(reset), .clr(cnt_clr), .inc(step && kx_max),
    .limit(kdim_q), .value(ky), .at_max(ky_max)
  );
  loop_level #(.W(OW)) u_ox (
    .clk(clk), .reset(reset), .clr(cnt_clr), .inc(step && kx_max && ky_max),
    .limit(odim_q), .value(ox), .at_max(ox_max)
  );
  loop_level #(.W(OW)) u_oy (
    .clk(clk), .reset(reset), .clr(cnt_clr),
    .inc(step && kx_max && ky_max && ox_max),
    .limit(odim_q), .value(oy), .at_max(oy_max)
  );

  always_comb begin
    state_d = state_q;
    kdim_d  = kdim_q;
    odim_d  = odim_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          kdim_d  = cfg_kdim;
          odim_d  = cfg_odim;
          state_d = (cfg_kdim == '0 || cfg_odim == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (beat && final_tuple) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      kdim_q  <= '0;
      odim_q  <= '0;
    end else begin
      state_q <= state_d;
      kdim_q  <= kdim_d;
      odim_q  <= odim_d;
    end
  end

  assign idx_vld  = run;
  assign idx_kx   = run ? kx : '0;
  assign idx_ky   = run ? ky : '0;
  assign idx_ox   = run ? ox : '0;
  assign idx_oy   = run ? oy : '0;
  assign acc_clr  = run && (kx == '0) && (ky == '0);
  assign acc_last = run && kx_max && ky_max;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv_loop_sched.sv
// Scoreboard bench for conv_loop_sched: a reference loop nest queues the
// expected tuples at start and every accepted beat is popped and compared.
module tb_conv_loop_sched;

  localparam int KW = 3;
  localparam int OW = 7;

  typedef struct packed {
    logic [KW-1:0] kx;
    logic [KW-1:0] ky;
    logic [OW-1:0] ox;
    logic [OW-1:0] oy;
    logic          clr;
    logic          last;
  } tup_t;

  logic          clk = 1'b0;
  logic          reset, start, abort, idx_rdy;
  logic [KW-1:0] cfg_kdim, idx_kx, idx_ky;
  logic [OW-1:0] cfg_odim, idx_ox, idx_oy;
  logic          idx_vld, acc_clr, acc_last, busy, done;

  int   n_cmp = 0;
  int   n_err = 0;
  tup_t exp_q[$];

  always #5 clk = ~clk;

  conv_loop_sched dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_kdim(cfg_kdim), .cfg_odim(cfg_odim),
    .idx_kx(idx_kx), .idx_ky(idx_ky), .idx_ox(idx_ox), .idx_oy(idx_oy),
    .idx_vld(idx_vld), .idx_rdy(idx_rdy),
    .acc_clr(acc_clr), .acc_last(acc_last), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_vld"},  idx_vld, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_clr"},  acc_clr, 0);
    check({tag, "_last"}, acc_last, 0);
    check({tag, "_idx"},  {idx_kx, idx_ky, idx_ox, idx_oy}, 0);
  endtask

  function automatic tup_t cur_tuple();
    tup_t t;
    t.kx = idx_kx; t.ky = idx_ky; t.ox = idx_ox; t.oy = idx_oy;
    t.clr = acc_clr; t.last = acc_last;
    return t;
  endfunction

  // abort_at: abort on the cycle that would carry beat number abort_at.
  // sstart_at: pulse start mid-run once that many beats have been accepted.
  task automatic do_run(input int k, input int o, input bit toggle,
                        input int abort_at, input int sstart_at);
    int   beats = 0, clrs = 0, lasts = 0, cyc = 0;
    int   first_cyc = -1, last_cyc = -1, done_cyc = -1, done_seen = 0;
    bit   aborted = 0, finished = 0, hold_pending = 0;
    tup_t held, cur, t;

    exp_q.delete();
    for (int oy = 0; oy < o; oy++)
      for (int ox = 0; ox < o; ox++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            t.kx = KW'(kx); t.ky = KW'(ky); t.ox = OW'(ox); t.oy = OW'(oy);
            t.clr  = (kx == 0) && (ky == 0);
            t.last = (kx == k - 1) && (ky == k - 1);
            exp_q.push_back(t);
          end

    @(negedge clk);
    cfg_kdim = KW'(k); cfg_odim = OW'(o); start = 1; abort = 0; idx_rdy = 1;
    #1;
    check("vld_in_start_cycle", idx_vld, 0);
    @(negedge clk);
    start = 0; cfg_kdim = '1; cfg_odim = '1;

    while (!finished && cyc < 3000) begin
      idx_rdy = toggle ? (cyc % 2 == 0) : 1'b1;
      abort   = !aborted && abort_at >= 0 && beats == abort_at - 1;
      start   = sstart_at >= 0 && beats == sstart_at;
      #1;
      cur = cur_tuple();
      if (cyc == 0) check("first_tuple_latency", idx_vld, (k != 0 && o != 0));
      if (done) done_seen++;
      if (aborted) begin
        check("abort_next_busy", busy, 0);
        check("abort_next_vld", idx_vld, 0);
        check("abort_next_done", done, 0);
        finished = 1;
      end else if (abort) begin
        aborted = 1;
      end else if (idx_vld && idx_rdy) begin
        if (hold_pending) check("hold_while_not_rdy", cur, held);
        hold_pending = 0;
        if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
        else check("tuple", cur, exp_q.pop_front());
        if (first_cyc < 0) first_cyc = cyc;
        beats++; clrs += int'(acc_clr); lasts += int'(acc_last);
        last_cyc = cyc;
      end else if (idx_vld && !hold_pending) begin
        held = cur;
        hold_pending = 1;
      end
      if (done && !aborted) begin
        done_cyc = cyc;
        finished = 1;
      end
      @(negedge clk);
      cyc++;
    end
    abort = 0; start = 0; idx_rdy = 1;

    if (!finished) check("run_timeout", 0, 1);
    if (aborted) begin
      check("abort_no_done", done_seen, 0);
      check("abort_beats", beats, abort_at - 1);
      exp_q.delete();
    end else begin
      check("beat_count", beats, o * o * k * k);
      check("acc_clr_count", clrs, (k != 0) ? o * o : 0);
      check("acc_last_count", lasts, (k != 0) ? o * o : 0);
      check("done_after_last", done_cyc, last_cyc + 1);
      check("queue_drained", exp_q.size(), 0);
      if (!toggle && beats > 0) check("beats_back_to_back", last_cyc - first_cyc, beats - 1);
      #1;
      check_quiet("after_done");
    end
  endtask

  initial begin
    reset = 0; start = 0; abort = 0; idx_rdy = 1; cfg_kdim = '0; cfg_odim = '0;
    repeat (3) @(negedge clk);
    #1;
    check_quiet("reset");
    reset = 1;

    do_run(3, 2, 0, -1, -1);
    do_run(2, 2, 1, -1, -1);
    do_run(0, 5, 0, -1, -1);
    do_run(2, 0, 0, -1, -1);
    do_run(3, 4, 0, 10, -1);
    do_run(3, 4, 0, -1, 5);

    @(negedge clk);
    cfg_kdim = 3; cfg_odim = 4; start = 1;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    #1;
    check("midrun_busy_before_reset", busy, 1);
    reset = 0;
    @(negedge clk);
    reset = 1;
    #1;
    check_quiet("midrun_reset");

    do_run(1, 3, 0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
